max_seq_ctrl: RTL
=================

// Module: max_seq_ctrl
// PURPOSE
//  Sequencer that streams a frame of COUNT unsigned samples through a shared
//  greater-than/max datapath and reports the frame maximum and its position.
//  Sits between a sample source (valid/ready) and consumers needing one
//  max result per frame.
//  Resolves equality itself: on a tie the running max is kept; the raw max
//  unit's "0 on equal" result is never forwarded.
// PARAMETERS
//  WIDTH  4  sample width, bits
//  COUNT  8  samples per frame; legal range 1..256
//  IDXW   $clog2(COUNT) (min 1)  width of index/counter fields; derived, do not override
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous reset, active-high
//  start     in   1      begin a frame; sampled in IDLE only
//  in_valid  in   1      in_data valid this cycle
//  in_data   in   WIDTH  sample, unsigned
//  in_ready  out  1      controller accepts in_data this cycle
//  busy      out  1      frame in progress (LOAD, SCAN or DONE)
//  max_out   out  WIDTH  registered frame maximum
//  max_idx   out  IDXW   position 0..COUNT-1 of max_out within the frame
//  done      out  1      one-cycle pulse: max_out/max_idx updated
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; in_ready=0, busy=0, done=0,
//    max_out=0, max_idx=0; internal run_max, run_idx and cnt cleared.
//  - Accept = in_valid & in_ready. Data with in_ready=0 is ignored, not queued.
//  - FSM states and transitions:
//    IDLE: in_ready=0, busy=0. start=1 -> LOAD next cycle.
//    LOAD: in_ready=1, busy=1. On accept: run_max=in_data, run_idx=0, cnt=1.
//          COUNT==1 -> DONE; else -> SCAN. No accept -> stay.
//    SCAN: in_ready=1, busy=1. On accept:
//          in_data>run_max -> run_max=in_data, run_idx=cnt.
//          in_data==run_max -> tie rule (see CONFIGURATION).
//          in_data<run_max -> no change. cnt=cnt+1 on every accept.
//          Accept with cnt==COUNT-1 -> DONE. No accept -> stay, hold all.
//    DONE: in_ready=0, busy=1, done=1 for exactly this cycle.
//          max_out/max_idx are loaded from the final run_max/run_idx and are
//          valid in this same cycle. -> IDLE unconditionally.
//  - Latency: done rises on the clock edge after the last accepted sample.
//    Minimum frame = 1 (start) + COUNT accept cycles + 1 (DONE).
//  - max_out/max_idx hold their value until the next DONE; they are not
//    cleared by start.
//  - start outside IDLE is ignored; start held high in DONE does not
//    retrigger. A new frame needs start sampled in IDLE.
//  - Comparison is unsigned, full WIDTH; no wrap, no saturation.
//    cnt never exceeds COUNT-1.
//  - All-equal frame: max = that value, max_idx per tie rule. All-zero frame
//    gives max_out=0.
//  - Reset mid-frame: partial frame discarded, outputs return to reset values.
// CONFIGURATION
//  MAX_SEQ_TIE_LAST_EN defined:   on a tie (in_data==run_max) run_idx=cnt,
//    so the latest occurrence is reported.
//  MAX_SEQ_TIE_LAST_EN undefined: on a tie run_idx is unchanged, so the
//    earliest occurrence is reported.
//  run_max is identical either way.
// TESTING (COUNT=8, WIDTH=4)
//  1. Reset then idle, no start -> in_ready=0, busy=0, done=0, max_out=0, max_idx=0.
//  2. start; stream 3,9,2,7,1,0,5,4 back-to-back -> done 1 cycle after the
//     8th accept; max_out=9, max_idx=1; busy low the cycle after done.
//  3. Frame 5,F,5,F,0,0,0,0 -> max_out=F; max_idx=1 without the macro,
//     max_idx=3 with MAX_SEQ_TIE_LAST_EN.
//  4. in_valid gaps of 0-3 cycles; start pulsed mid-frame -> result
//     unchanged vs. test 2; no extra frame is started.
//  5. rst asserted after 4 accepts -> next cycle: IDLE, outputs at reset
//     values. Full frame afterwards gives the correct fresh result.
//  6. COUNT=1 build: start, one sample A -> done next cycle, max_out=A, max_idx=0.

Source files
------------

// File: rtl/max_seq_ctrl.sv
// Frame max sequencer: streams COUNT samples through a greater-than compare and reports max and position.
// Build option: define MAX_SEQ_TIE_LAST_EN to report the latest tied position instead of the earliest.
module max_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned COUNT = 8,
  parameter int unsigned IDXW  = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic [WIDTH-1:0] max_out,
  output logic [IDXW-1:0]  max_idx,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_max_out;
  logic [IDXW-1:0]  r_max_idx;
  logic [WIDTH-1:0] r_run_max;
  logic [IDXW-1:0]  r_run_idx;
  logic [IDXW-1:0]  r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_gt;
  logic             w_take_idx;
  logic [WIDTH-1:0] w_nxt_max;
  logic [IDXW-1:0]  w_nxt_idx;

  // Running max update; ties never replace run_max, only (optionally) run_idx
  always_comb begin
    w_accept  = in_valid & r_in_ready;
    w_last    = (r_cnt == IDXW'(COUNT - 1));
    w_gt      = (in_data > r_run_max);
`ifdef MAX_SEQ_TIE_LAST_EN
    w_take_idx = w_gt | (in_data == r_run_max);
`else
    w_take_idx = w_gt;
`endif
    w_nxt_max = r_run_max;
    w_nxt_idx = r_run_idx;
    if (r_state == S_LOAD) begin
      w_nxt_max = in_data;
      w_nxt_idx = '0;
    end else begin
      if (w_gt)       w_nxt_max = in_data;
      if (w_take_idx) w_nxt_idx = r_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_max_out  <= '0;
      r_max_idx  <= '0;
      r_run_max  <= '0;
      r_run_idx  <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
          end
        end
        S_LOAD, S_SCAN: begin
          if (w_accept) begin
            r_run_max <= w_nxt_max;
            r_run_idx <= w_nxt_idx;
            // In LOAD cnt is 0, so w_last also covers the single-sample frame
            if (w_last) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
              r_max_out  <= w_nxt_max;
              r_max_idx  <= w_nxt_idx;
              r_cnt      <= '0;
            end else begin
              r_state <= S_SCAN;
              r_cnt   <= r_cnt + IDXW'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign max_out  = r_max_out;
  assign max_idx  = r_max_idx;

endmodule
